// File: rtl/stage_arbiter.sv
// Two-requester arbiter feeding one shared handshake stage (dor/dir/ack).
// Optional macro ARB_ROUND_ROBIN_EN turns fixed priority into round-robin tie-breaking.
//
// state   | meaning
// IDLE    | no transfer; a ready requester is captured on the next edge
// OFFER   | data_out/dir_out presented to the stage, waiting for ack_in
// RELEASE | one-cycle ack to the winner; requests ignored so it can drop dor
module stage_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_dor,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ack,
    input  logic             req1_dor,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ack,
    output logic             dir_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack_in,
    output logic [1:0]       grant
);

    typedef enum logic [1:0] {IDLE, OFFER, RELEASE} state_t;

    state_t           state, state_nxt;
    logic             dir_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic [1:0]       grant_nxt;
    logic             ack0_nxt, ack1_nxt;
    logic             last_grant, last_nxt;   // 0 = requester 0, 1 = requester 1
    logic             pick1;

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        pick1 = req1_dor & (~req0_dor | ~last_grant);
`else
        pick1 = req1_dor & ~req0_dor;
`endif
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_out;
        data_nxt  = data_out;
        grant_nxt = grant;
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        last_nxt  = last_grant;
        case (state)
            IDLE: begin
                if (req0_dor || req1_dor) begin
                    state_nxt = OFFER;
                    dir_nxt   = 1'b1;
                    data_nxt  = pick1 ? req1_data : req0_data;
                    grant_nxt = pick1 ? 2'b10 : 2'b01;
                end else begin
                    dir_nxt   = 1'b0;
                    grant_nxt = 2'b00;
                end
            end
            OFFER: begin
                if (ack_in) begin
                    state_nxt = RELEASE;
                    dir_nxt   = 1'b0;
                    ack0_nxt  = grant[0];
                    ack1_nxt  = grant[1];
                    last_nxt  = grant[1];
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
            end
            default: begin
                state_nxt = IDLE;
                dir_nxt   = 1'b0;
                grant_nxt = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            dir_out    <= 1'b0;
            data_out   <= '0;
            grant      <= 2'b00;
            req0_ack   <= 1'b0;
            req1_ack   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            dir_out    <= dir_nxt;
            data_out   <= data_nxt;
            grant      <= grant_nxt;
            req0_ack   <= ack0_nxt;
            req1_ack   <= ack1_nxt;
            last_grant <= last_nxt;
        end
    end

endmodule

// File: tb/tb_stage_arbiter.sv
// Directed self-checking bench for stage_arbiter; the tie test follows ARB_ROUND_ROBIN_EN.
module tb_stage_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_dor, req1_dor, req0_ack, req1_ack;
    logic [7:0] req0_data, req1_data, data_out;
    logic       dir_out, ack_in;
    logic [1:0] grant;

    int checks = 0;
    int passes = 0;

    stage_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .req0_dor(req0_dor), .req0_data(req0_data), .req0_ack(req0_ack),
        .req1_dor(req1_dor), .req1_data(req1_data), .req1_ack(req1_ack),
        .dir_out(dir_out), .data_out(data_out), .ack_in(ack_in), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req0_dor = 0; req1_dor = 0; ack_in = 0;
        req0_data = 8'h00; req1_data = 8'h00;
        tick(); tick();
        checks++;
        if ({dir_out, data_out, grant, req0_ack, req1_ack} !== 13'd0)
            $display("FAIL reset_state: got dir=%b data=%h grant=%b ack0=%b ack1=%b, want all 0",
                     dir_out, data_out, grant, req0_ack, req1_ack);
        else passes++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_req0();
        req0_dor = 1; req0_data = 8'h12;
        tick();
        checks++;
        if ({dir_out, grant, data_out} !== {1'b1, 2'b01, 8'h12})
            $display("FAIL single_offer: got dir=%b grant=%b data=%h, want 1 01 12", dir_out, grant, data_out);
        else passes++;
        tick();
        checks++;
        if ({dir_out, grant, req0_ack} !== {1'b1, 2'b01, 1'b0})
            $display("FAIL single_hold: got dir=%b grant=%b ack0=%b, want 1 01 0", dir_out, grant, req0_ack);
        else passes++;
        ack_in = 1;
        tick();
        ack_in = 0; req0_dor = 0;
        checks++;
        if ({req0_ack, req1_ack, dir_out, data_out} !== {1'b1, 1'b0, 1'b0, 8'h12})
            $display("FAIL single_ack: got ack0=%b ack1=%b dir=%b data=%h, want 1 0 0 12",
                     req0_ack, req1_ack, dir_out, data_out);
        else passes++;
        tick();
        checks++;
        if ({req0_ack, grant, data_out} !== {1'b0, 2'b00, 8'h12})
            $display("FAIL single_release: got ack0=%b grant=%b data=%h, want 0 00 12", req0_ack, grant, data_out);
        else passes++;
        tick();
        checks++;
        if ({req0_ack, grant, dir_out} !== 4'b0000)
            $display("FAIL single_idle: got ack0=%b grant=%b dir=%b, want 0 00 0", req0_ack, grant, dir_out);
        else passes++;
    endtask

    task automatic test_ack_in_idle();
        ack_in = 1;
        tick();
        ack_in = 0;
        checks++;
        if ({req0_ack, req1_ack, dir_out, grant, data_out} !== {5'b00000, 8'h12})
            $display("FAIL ack_idle: got ack0=%b ack1=%b dir=%b grant=%b data=%h, want 0 0 0 00 12",
                     req0_ack, req1_ack, dir_out, grant, data_out);
        else passes++;
    endtask

    task automatic test_lone_req1();
        req1_dor = 1; req1_data = 8'h3E;
        tick();
        checks++;
        if ({dir_out, grant, data_out} !== {1'b1, 2'b10, 8'h3E})
            $display("FAIL lone_req1: got dir=%b grant=%b data=%h, want 1 10 3e", dir_out, grant, data_out);
        else passes++;
        ack_in = 1;
        tick();
        ack_in = 0; req1_dor = 0;
        checks++;
        if ({req1_ack, req0_ack} !== 2'b10)
            $display("FAIL lone_req1_ack: got ack1=%b ack0=%b, want 1 0", req1_ack, req0_ack);
        else passes++;
        tick();
    endtask

    task automatic test_tie();
        logic [1:0] exp_g;
        logic [7:0] exp_d;
        req0_dor = 1; req0_data = 8'hA0;
        req1_dor = 1; req1_data = 8'hB1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            exp_d = exp_g[0] ? 8'hA0 : 8'hB1;
            tick();
            checks++;
            if ({grant, data_out, dir_out} !== {exp_g, exp_d, 1'b1})
                $display("FAIL tie_grant_%0d: got grant=%b data=%h dir=%b, want %b %h 1",
                         i, grant, data_out, dir_out, exp_g, exp_d);
            else passes++;
            ack_in = 1;
            tick();
            ack_in = 0;
            checks++;
            if ({req0_ack, req1_ack} !== {exp_g[0], exp_g[1]})
                $display("FAIL tie_ack_%0d: got ack0=%b ack1=%b, want %b %b",
                         i, req0_ack, req1_ack, exp_g[0], exp_g[1]);
            else passes++;
            tick();
            checks++;
            if ({grant, req0_ack, req1_ack} !== 4'b0000)
                $display("FAIL tie_release_%0d: got grant=%b ack0=%b ack1=%b, want 00 0 0",
                         i, grant, req0_ack, req1_ack);
            else passes++;
        end
        req0_dor = 0; req1_dor = 0;
        tick();
    endtask

    task automatic test_reset_in_offer();
        req1_dor = 1; req1_data = 8'hC7;
        tick();
        checks++;
        if ({grant, data_out} !== {2'b10, 8'hC7})
            $display("FAIL rst_offer_setup: got grant=%b data=%h, want 10 c7", grant, data_out);
        else passes++;
        reset = 0;
        tick();
        reset = 1; req1_dor = 0; ack_in = 1;
        checks++;
        if ({dir_out, data_out, grant, req0_ack, req1_ack} !== 13'd0)
            $display("FAIL rst_offer_clear: got dir=%b data=%h grant=%b ack0=%b ack1=%b, want all 0",
                     dir_out, data_out, grant, req0_ack, req1_ack);
        else passes++;
        tick();
        ack_in = 0;
        checks++;
        if ({req1_ack, req0_ack, grant} !== 4'b0000)
            $display("FAIL rst_offer_noack: got ack1=%b ack0=%b grant=%b, want 0 0 00", req1_ack, req0_ack, grant);
        else passes++;
        // first tie after reset belongs to requester 0
        req0_dor = 1; req0_data = 8'h44; req1_dor = 1; req1_data = 8'h55;
        tick();
        checks++;
        if ({grant, data_out} !== {2'b01, 8'h44})
            $display("FAIL rst_first_tie: got grant=%b data=%h, want 01 44", grant, data_out);
        else passes++;
        ack_in = 1;
        tick();
        ack_in = 0; req0_dor = 0; req1_dor = 0;
        tick();
        tick();
    endtask

    task automatic test_drop_in_offer();
        req0_dor = 1; req0_data = 8'h5C;
        tick();
        req0_dor = 0; req0_data = 8'hFF;
        tick();
        checks++;
        if ({dir_out, grant, data_out} !== {1'b1, 2'b01, 8'h5C})
            $display("FAIL drop_hold: got dir=%b grant=%b data=%h, want 1 01 5c", dir_out, grant, data_out);
        else passes++;
        ack_in = 1;
        tick();
        ack_in = 0;
        checks++;
        if ({req0_ack, data_out} !== {1'b1, 8'h5C})
            $display("FAIL drop_ack: got ack0=%b data=%h, want 1 5c", req0_ack, data_out);
        else passes++;
        tick();
        checks++;
        if (req0_ack !== 1'b0)
            $display("FAIL drop_ack_once: got ack0=%b, want 0", req0_ack);
        else passes++;
        tick();
        checks++;
        if ({req0_ack, dir_out, grant} !== 4'b0000)
            $display("FAIL drop_idle: got ack0=%b dir=%b grant=%b, want 0 0 00", req0_ack, dir_out, grant);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_req0();
        test_ack_in_idle();
        test_lone_req1();
        test_tie();
        test_reset_in_offer();
        test_drop_in_offer();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
